// File: rtl/dbus_ram_responder.sv
// Word-organised data RAM on the core DBus: zero-wait writes with lane steering, reads with
// READ_LATENCY wait states, and combinational rejection of illegal requests while idle.

module dbus_ram_lane #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wr_byte,
  output logic [7:0]    rd_byte
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wr_byte;

  assign rd_byte = mem[idx];
endmodule

module dbus_ram_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          DEPTH        = 1024,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbus_rd_en,
  input  logic        dbus_wr_en,
  input  logic [31:0] dbus_addr,
  input  logic [31:0] dbus_wr_data,
  input  logic [3:0]  dbus_wr_strobe,
  output logic [31:0] dbus_rd_data,
  output logic        dbus_wait,
  output logic        dbus_err
);
  localparam int         NUM_LANES = 4;
  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1    = 4'(READ_LATENCY - 1);

  if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_lat
    $fatal(1, "dbus_ram_responder: READ_LATENCY must be 1..15");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "dbus_ram_responder: DEPTH must be a power of 2, >= 2");
  end
  if (BASE_ADDR[AW+1:0] != '0) begin : g_bad_base
    $fatal(1, "dbus_ram_responder: BASE_ADDR must be DEPTH*4 aligned");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] rd_buf;
  logic [1:0]  off_q;

  logic                           hit, err_c, idle, rd_go, wr_go;
  logic [AW-1:0]                  idx;
  logic [1:0]                     off;
  logic [NUM_LANES-1:0]           lane_mask;
  logic [31:0]                    wd_sh;
  logic [NUM_LANES-1:0][7:0]      lane_rd;

  // BASE_ADDR is window-aligned, so the hit test is a compare of the upper bits only
  assign hit = (dbus_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign idx = dbus_addr[AW+1:2];
  assign off = dbus_addr[1:0];

  always_comb begin
    err_c = 1'b0;
    if ((dbus_rd_en || dbus_wr_en) && !hit) err_c = 1'b1;
    if (dbus_rd_en && dbus_wr_en)           err_c = 1'b1;
    if (dbus_wr_en) begin
      case (dbus_wr_strobe)
        4'h1:    ;
        4'h3:    if (off[0])     err_c = 1'b1;
        4'hF:    if (off != '0)  err_c = 1'b1;
        default: err_c = 1'b1;
      endcase
    end
  end

  assign idle     = (state == S_IDLE);
  assign dbus_err = idle & err_c;
  assign rd_go    = idle & dbus_rd_en & ~err_c;
  assign wr_go    = idle & dbus_wr_en & ~err_c;

  // legal strobe/offset pairs never spill past lane 3, so truncation is safe
  assign lane_mask = dbus_wr_strobe << off;
  assign wd_sh     = dbus_wr_data << {off, 3'b000};

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    dbus_ram_lane #(.DEPTH(DEPTH), .AW(AW)) u_lane (
      .clk     (clk),
      .we      (wr_go & lane_mask[k]),
      .idx     (idx),
      .wr_byte (wd_sh[8*k +: 8]),
      .rd_byte (lane_rd[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rd_buf <= '0;
      off_q  <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (rd_go) begin
            rd_buf <= lane_rd;
            off_q  <= off;
            cnt    <= LAT_M1;
            state  <= (LAT_M1 == 4'd0) ? S_RESP : S_WAIT;
          end
        S_WAIT:
          if (!dbus_rd_en) begin
            state  <= S_IDLE;
            cnt    <= '0;
            rd_buf <= '0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= S_RESP;
          end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbus_wait    = rd_go | (state == S_WAIT);
  assign dbus_rd_data = (state == S_RESP) ? (rd_buf >> {off_q, 3'b000}) : 32'h0;
endmodule

// File: tb/tb_dbus_ram_responder.sv
// Random and directed load/store traffic against two responders (latency 1 and 3), checked
// against a word-array reference model of the bus rules.

module tb_dbus_ram_responder;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 64;
  localparam int          LAT0  = 1;
  localparam int          LAT1  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en [2];
  logic        wr_en [2];
  logic [31:0] addr  [2];
  logic [31:0] wd    [2];
  logic [3:0]  st    [2];
  logic [31:0] rdd   [2];
  logic        wt    [2];
  logic        er    [2];

  logic [31:0] ref_mem [2][DEPTH];
  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dbus_ram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .READ_LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst(rst), .dbus_rd_en(rd_en[0]), .dbus_wr_en(wr_en[0]), .dbus_addr(addr[0]),
    .dbus_wr_data(wd[0]), .dbus_wr_strobe(st[0]), .dbus_rd_data(rdd[0]), .dbus_wait(wt[0]),
    .dbus_err(er[0]));

  dbus_ram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .READ_LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst(rst), .dbus_rd_en(rd_en[1]), .dbus_wr_en(wr_en[1]), .dbus_addr(addr[1]),
    .dbus_wr_data(wd[1]), .dbus_wr_strobe(st[1]), .dbus_rd_data(rdd[1]), .dbus_wait(wt[1]),
    .dbus_err(er[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_err(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] s);
    longint ua;
    bit     hit;
    ua  = {32'b0, a};
    hit = (ua >= longint'(BASE)) && (ua < longint'(BASE) + 4 * DEPTH);
    if ((rd || wr) && !hit) return 1'b1;
    if (rd && wr) return 1'b1;
    if (wr) begin
      if (!(s == 4'h1 || s == 4'h3 || s == 4'hF)) return 1'b1;
      if (s == 4'h3 && a[0]) return 1'b1;
      if (s == 4'hF && a[1:0] != 2'b00) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] data, input logic [3:0] s);
    bit e;
    e = exp_err(1'b0, 1'b1, a, s);
    rd_en[d] = 1'b0; wr_en[d] = 1'b1; addr[d] = a; wd[d] = data; st[d] = s;
    @(negedge clk);
    chk("wr_err",  32'(er[d]), 32'(e));
    chk("wr_wait", 32'(wt[d]), 32'd0);
    chk("wr_rdz",  rdd[d],     32'd0);
    @(posedge clk); #1;
    wr_en[d] = 1'b0;
    if (!e)
      for (int k = 0; k < 4; k++)
        if (s[k]) ref_mem[d][widx(a)][8*(k + int'(a[1:0])) +: 8] = data[8*k +: 8];
  endtask

  task automatic do_read(input int d, input logic [31:0] a, output logic [31:0] got);
    bit          e;
    logic [31:0] expv;
    int          n;
    e    = exp_err(1'b1, 1'b0, a, 4'h0);
    expv = 32'h0;
    if (!e) expv = ref_mem[d][widx(a)] >> (8 * int'(a[1:0]));
    rd_en[d] = 1'b1; wr_en[d] = 1'b0; addr[d] = a;
    n = 0; got = 32'h0;
    @(negedge clk);
    chk("rd_err", 32'(er[d]), 32'(e));
    if (e) begin
      chk("rd_err_wait", 32'(wt[d]), 32'd0);
      chk("rd_err_rdz",  rdd[d],     32'd0);
    end else begin
      while (wt[d] && n < 20) begin
        chk("rd_wait_rdz", rdd[d], 32'd0);
        n++;
        @(posedge clk); #1;
        @(negedge clk);
      end
      chk("rd_lat",  32'(n),   32'(lat_of(d)));
      chk("rd_data", rdd[d],   expv);
      chk("rd_noerr", 32'(er[d]), 32'd0);
      got = rdd[d];
    end
    @(posedge clk); #1;
    rd_en[d] = 1'b0;
  endtask

  task automatic do_both(input int d, input logic [31:0] a);
    rd_en[d] = 1'b1; wr_en[d] = 1'b1; addr[d] = a; wd[d] = $urandom; st[d] = 4'hF;
    @(negedge clk);
    chk("both_err",  32'(er[d]), 32'(exp_err(1'b1, 1'b1, a, 4'hF)));
    chk("both_wait", 32'(wt[d]), 32'd0);
    @(posedge clk); #1;
    rd_en[d] = 1'b0; wr_en[d] = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 90) return BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
    if (r < 94) return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
    if (r < 97) return BASE - 32'($urandom_range(1, 8));
    return $urandom;
  endfunction

  function automatic logic [3:0] rand_strobe();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 30) return 4'h1;
    if (r < 60) return 4'h3;
    if (r < 88) return 4'hF;
    return 4'($urandom);
  endfunction

  initial begin
    logic [31:0] got;
    for (int d = 0; d < 2; d++) begin
      rd_en[d] = 1'b0; wr_en[d] = 1'b0; addr[d] = '0; wd[d] = '0; st[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_wait", 32'(wt[d]), 32'd0);
      chk("rst_err",  32'(er[d]), 32'd0);
      chk("rst_rdz",  rdd[d],     32'd0);
    end
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) do_write(d, BASE + 32'(4 * i), $urandom, 4'hF);

    // directed: lane steering and rejected requests on the latency-1 instance
    do_write(0, BASE + 32'h8, 32'hA5A5_1234, 4'hF);
    do_read(0, BASE + 32'h8, got);             chk("lw8",   got, 32'hA5A5_1234);
    do_write(0, BASE + 32'hB, 32'h0000_00EE, 4'h1);
    do_read(0, BASE + 32'h8, got);             chk("lw8b",  got, 32'hEEA5_1234);
    do_read(0, BASE + 32'hB, got);             chk("lbu_b", got, 32'h0000_00EE);
    do_write(0, BASE + 32'h9, 32'h0000_BEEF, 4'h3);
    do_write(0, BASE + 32'h2, 32'hDEAD_BEEF, 4'hF);
    do_read(0, BASE + 32'(4 * DEPTH), got);
    do_both(0, BASE + 32'h8);
    do_read(0, BASE + 32'h8, got);             chk("lw8_kept", got, 32'hEEA5_1234);
    do_write(0, BASE, 32'h1111_2222, 4'hF);
    do_read(0, BASE, got);                     chk("raw", got, 32'h1111_2222);

    // latency-3 read, then abort after one wait cycle
    do_read(1, BASE + 32'h10, got);
    rd_en[1] = 1'b1; addr[1] = BASE + 32'h14;
    @(posedge clk); #1;
    rd_en[1] = 1'b0;
    @(negedge clk);
    chk("abort_rdz", rdd[1], 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_idle_wait", 32'(wt[1]), 32'd0);
      chk("abort_idle_rdz",  rdd[1],     32'd0);
    end
    @(posedge clk); #1;

    // reset in the middle of a wait, RAM must survive
    rd_en[1] = 1'b1; addr[1] = BASE + 32'h20;
    @(posedge clk); #1;
    rst = 1'b1; rd_en[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_wait", 32'(wt[1]), 32'd0);
    chk("mid_rst_rdz",  rdd[1],     32'd0);
    @(posedge clk); #1;
    do_read(1, BASE + 32'h20, got);
    do_read(0, BASE + 32'h8, got);             chk("post_rst_lw8", got, 32'hEEA5_1234);

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 5000; i++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 45)      do_read(d, rand_addr(), got);
        else if (r < 90) do_write(d, rand_addr(), $urandom, rand_strobe());
        else if (r < 95) do_both(d, rand_addr());
        else begin
          @(negedge clk);
          chk("idle_wait", 32'(wt[d]), 32'd0);
          chk("idle_rdz",  rdd[d],     32'd0);
          @(posedge clk); #1;
        end
      end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
